gprf_bus1_seq: RTL

- Upstream bus-1 sequencer for the GPRF. Accepts one register-move command at a time over a valid/ready handshake.
- Decodes the command into one-hot GPRF read and write selects, then drives bus1_dat. Sequences read -> capture -> write on a single shared bus.
- Sits between the ASIP decode stage and gprf. Top level splits the select vectors onto gprf's per-register bus1_rN_t_sel / bus1_rN_r_sel pins.

---
 rtl/gprf_bus1_seq_pkg.sv | 21 ++
 rtl/gprf_bus1_seq_if.sv | 40 ++++
 rtl/gprf_bus1_seq_onehot_dec.sv | 24 ++
 rtl/gprf_bus1_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/gprf_bus1_seq_pkg.sv
// Shared constants and types for the GPRF bus-1 sequencer.
// Contents:
//   DEF_DAT_W - default bus data width
//   DEF_NREG  - default number of GPRF registers
//   REG_IDX_W - width of a register index field
//   state_e   - sequencer state encoding
package gprf_bus1_seq_pkg;

  localparam int DEF_DAT_W = 32;
  localparam int DEF_NREG  = 20;
  localparam int REG_IDX_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_OUT  = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

// File: rtl/gprf_bus1_seq_if.sv
// Command handshake plus GPRF bus-1 signals of the sequencer.
// Modports:
//   slave  - the sequencer: takes commands and GPRF read data, drives
//            selects, write data, rd_dat, done and err.
//   master - the decode stage / GPRF side, the mirror image.
interface gprf_bus1_seq_if
  import gprf_bus1_seq_pkg::*;
#(
  parameter int DAT_W = DEF_DAT_W,
  parameter int NREG  = DEF_NREG
);

  logic                 req_vld;
  logic                 req_rdy;
  logic [REG_IDX_W-1:0] req_src;
  logic                 req_src_ext;
  logic [REG_IDX_W-1:0] req_dst;
  logic                 req_dst_ext;
  logic [DAT_W-1:0]     ext_dat;
  logic [NREG-1:0]      bus1_r_sel;
  logic [NREG-1:0]      bus1_t_sel;
  logic [DAT_W-1:0]     bus1_dat;
  logic [DAT_W-1:0]     bus1_gprf_r_dat;
  logic [DAT_W-1:0]     rd_dat;
  logic                 done;
  logic                 err;

  modport slave (
    input  req_vld, req_src, req_src_ext, req_dst, req_dst_ext, ext_dat,
    input  bus1_gprf_r_dat,
    output req_rdy, bus1_r_sel, bus1_t_sel, bus1_dat, rd_dat, done, err
  );

  modport master (
    output req_vld, req_src, req_src_ext, req_dst, req_dst_ext, ext_dat,
    output bus1_gprf_r_dat,
    input  req_rdy, bus1_r_sel, bus1_t_sel, bus1_dat, rd_dat, done, err
  );

endinterface

// File: rtl/gprf_bus1_seq_onehot_dec.sv
// Register index to one-hot select decoder.
// Ports:
//   idx - register index
//   en  - decode enable
//   oh  - NREG-bit one-hot select; all zero when disabled or idx >= NREG
module onehot_dec
  import gprf_bus1_seq_pkg::*;
#(
  parameter int NREG = DEF_NREG
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NREG-1:0]      oh
);

  // Compare against every position so out-of-range indices decode to zero.
  always_comb begin
    oh = '0;
    for (int i = 0; i < NREG; i++) begin
      oh[i] = en && (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/gprf_bus1_seq.sv
// Upstream bus-1 sequencer for the GPRF. Takes one register-move command
// at a time and sequences read -> capture -> write on the shared bus.
// Ports:
//   clk   - system clock, rising edge
//   rst_b - synchronous reset, active high (1 = reset)
//   bus   - command handshake and GPRF bus-1 signals (slave modport)
// All outputs are registered; selects are computed one cycle ahead from
// the next-state decision so they line up with the state they belong to.
module gprf_bus1_seq
  import gprf_bus1_seq_pkg::*;
#(
  parameter int DAT_W  = DEF_DAT_W,
  parameter int NREG   = DEF_NREG,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst_b,
  gprf_bus1_seq_if.slave bus
);

  localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

  state_e               state_r;
  logic [1:0]           cnt_r;
  logic [REG_IDX_W-1:0] src_r;
  logic [REG_IDX_W-1:0] dst_r;
  logic                 dst_ext_r;
  logic                 req_rdy_r;
  logic [NREG-1:0]      r_sel_r;
  logic [NREG-1:0]      t_sel_r;
  logic [DAT_W-1:0]     bus1_dat_r;
  logic [DAT_W-1:0]     rd_dat_r;
  logic                 done_r;
  logic                 err_r;

  logic                 accept_s;
  logic                 bad_s;
  logic                 rd_last_s;
  logic                 go_rd_s;
  logic                 go_wr_s;
  logic [REG_IDX_W-1:0] rd_idx_s;
  logic [REG_IDX_W-1:0] wr_idx_s;
  logic [NREG-1:0]      rd_oh_s;
  logic [NREG-1:0]      wr_oh_s;

  // Accept/validation decode and the next-cycle select requests.
  always_comb begin
    accept_s  = bus.req_vld && (state_r == ST_IDLE);
    bad_s     = (!bus.req_src_ext && (32'(bus.req_src) >= 32'(NREG))) ||
                (!bus.req_dst_ext && (32'(bus.req_dst) >= 32'(NREG))) ||
                (bus.req_src_ext && bus.req_dst_ext);
    rd_last_s = (state_r == ST_RD) && (cnt_r == LAST_CNT);
    // Stay in RD until the last latency cycle; enter RD only for register sources.
    go_rd_s   = (accept_s && !bad_s && !bus.req_src_ext) ||
                ((state_r == ST_RD) && !rd_last_s);
    go_wr_s   = (accept_s && !bad_s && bus.req_src_ext) ||
                (rd_last_s && !dst_ext_r);
    // In IDLE the live command fields are used; afterwards the latched ones.
    if (state_r == ST_IDLE) begin
      rd_idx_s = bus.req_src;
      wr_idx_s = bus.req_dst;
    end else begin
      rd_idx_s = src_r;
      wr_idx_s = dst_r;
    end
  end

  onehot_dec #(.NREG(NREG)) u_rd_dec (.idx(rd_idx_s), .en(go_rd_s), .oh(rd_oh_s));
  onehot_dec #(.NREG(NREG)) u_wr_dec (.idx(wr_idx_s), .en(go_wr_s), .oh(wr_oh_s));

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      src_r      <= '0;
      dst_r      <= '0;
      dst_ext_r  <= 1'b0;
      req_rdy_r  <= 1'b1;
      r_sel_r    <= '0;
      t_sel_r    <= '0;
      bus1_dat_r <= '0;
      rd_dat_r   <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      r_sel_r    <= rd_oh_s;
      t_sel_r    <= wr_oh_s;
      bus1_dat_r <= '0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      req_rdy_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            src_r     <= bus.req_src;
            dst_r     <= bus.req_dst;
            dst_ext_r <= bus.req_dst_ext;
            cnt_r     <= 2'd0;
            if (bad_s) begin
              state_r <= ST_ERR;
              err_r   <= 1'b1;
            end else if (bus.req_src_ext) begin
              // External data goes straight to the write cycle.
              state_r    <= ST_WR;
              bus1_dat_r <= bus.ext_dat;
              done_r     <= 1'b1;
            end else begin
              state_r <= ST_RD;
            end
          end else begin
            req_rdy_r <= 1'b1;
          end
        end
        ST_RD: begin
          if (rd_last_s) begin
            done_r <= 1'b1;
            if (dst_ext_r) begin
              state_r  <= ST_OUT;
              rd_dat_r <= bus.bus1_gprf_r_dat;
            end else begin
              state_r    <= ST_WR;
              bus1_dat_r <= bus.bus1_gprf_r_dat;
            end
          end else begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        ST_WR, ST_OUT, ST_ERR: begin
          state_r   <= ST_IDLE;
          req_rdy_r <= 1'b1;
        end
        default: begin
          state_r   <= ST_IDLE;
          req_rdy_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_rdy    = req_rdy_r;
  assign bus.bus1_r_sel = r_sel_r;
  assign bus.bus1_t_sel = t_sel_r;
  assign bus.bus1_dat   = bus1_dat_r;
  assign bus.rd_dat     = rd_dat_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule
